gray_conv_arbiter: RTL

- Shares one registered binary-to-Gray conversion stage between NUM_REQ requesters using round-robin arbitration.
- Each requester presents a binary word with a valid/ready handshake. The winner's word is converted (gray = bin ^ (bin >> 1)) and held in a one-entry output register, tagged with the requester index.
- Sits between multiple pointer/counter sources (FIFO pointers, position counters) and a single downstream Gray-code consumer.

---
 rtl/gray_conv_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter feeding one registered binary-to-Gray stage with a one-entry output register.
// Optional macro GRAY_ARB_STATS_EN adds per-requester saturating accept counters (grant_cnt).
module gray_conv_arbiter #(
  parameter  int WIDTH   = 8,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_gray,
  output logic [ID_W-1:0]          out_id
`ifdef GRAY_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]    grant_cnt
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  gray_q, gray_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic              found;
  logic [ID_W-1:0]   win_idx;
  logic [WIDTH-1:0]  win_data;
  int                arb_idx;
  logic              can_load;
  logic              accept;

  // Rotating priority search: first valid requester at or after rr_ptr_q, wrapping.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    win_data = '0;
    arb_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[arb_idx]) begin
        found    = 1'b1;
        win_idx  = ID_W'(arb_idx);
        win_data = req_data[arb_idx*WIDTH +: WIDTH];
      end
    end
  end

  // Reset gating keeps req_ready low so no handshake completes while rst_n is asserted.
  assign can_load = rst_n && ((state_q == EMPTY) || out_ready);
  assign accept   = found && can_load;

  // State register
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      gray_q   <= '0;
      id_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gray_q   <= gray_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state logic; the held result and the priority pointer only move on accept.
  always_comb begin
    state_d  = state_q;
    gray_d   = gray_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      state_d  = FULL;
      gray_d   = win_data ^ (win_data >> 1);
      id_d     = win_idx;
      rr_ptr_d = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  // Output logic
  always_comb begin
    out_valid = (state_q == FULL);
    out_gray  = gray_q;
    out_id    = id_q;
    req_ready = '0;
    if (accept) begin
      req_ready = NUM_REQ'(1) << win_idx;
    end
  end

`ifdef GRAY_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (accept && (cnt_q[win_idx] != 16'hFFFF)) begin
      cnt_q[win_idx] <= cnt_q[win_idx] + 16'd1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*16 +: 16] = cnt_q[i];
    end
  end
`endif

endmodule
